// File: rtl/bcd_sseg_scan_driver.sv
// Time-multiplexed N-digit BCD to seven-segment scanner with an anode-off guard interval.
// Optional leading-zero blanking is enabled by defining SSEG_LZ_BLANK_EN.
module bcd_sseg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic [4*DIGITS-1:0] bcd,
  input  logic [DIGITS-1:0]   dp_n,
  output logic [DIGITS-1:0]   an,
  output logic [7:0]          sseg,
  output logic                frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_V = CW'(GUARD);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] bcd_sh;
  logic [DIGITS-1:0]   dp_sh;
  logic                tick;
  logic                last;
  logic [3:0]          nib;
  logic [6:0]          seg7;

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign tick = en && (cnt == CNT_MAX);
  assign last = (idx == IDX_MAX);
  assign nib  = bcd_sh[{idx, 2'b00} +: 4];

`ifdef SSEG_LZ_BLANK_EN
  logic [DIGITS-1:0] lz;

  // lz[i]: nibbles i..DIGITS-1 are all zero
  always_comb begin
    logic run;
    run = 1'b1;
    lz  = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      run   = run && (bcd_sh[4*i +: 4] == 4'd0);
      lz[i] = run;
    end
  end

  assign seg7 = lz[idx] ? 7'h7F : seg_code(nib);
`else
  assign seg7 = seg_code(nib);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      idx        <= '0;
      bcd_sh     <= '0;
      dp_sh      <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= tick && last;
      if (tick) begin
        cnt <= '0;
        idx <= last ? '0 : idx + 1'b1;
        // Shadow reload only at frame boundary keeps a frame tear-free
        if (last) begin
          bcd_sh <= bcd;
          dp_sh  <= dp_n;
        end
      end else if (en) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an   <= '1;
      sseg <= 8'hFF;
    end else if (!en) begin
      an   <= '1;
      sseg <= 8'hFF;
    end else begin
      sseg <= {dp_sh[idx], seg7};
      an   <= (cnt < GUARD_V) ? '1 : ~(DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_bcd_sseg_scan_driver.sv
// Scoreboard bench for bcd_sseg_scan_driver: frame-level model, queue, negedge monitor.
// Honours SSEG_LZ_BLANK_EN in the reference model.
module tb_bcd_sseg_scan_driver;

  localparam int D = 4;
  localparam int R = 8;
  localparam int G = 2;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] sseg;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] bcd = 16'h0;
  logic [3:0]  dp_n = 4'hF;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_done;

  int checks = 0;
  int failures = 0;
  bit active = 1'b0;
  exp_t exp_q[$];

  // model state: enabled edges since reset and the frame-latched display data
  int          e;
  logic [15:0] sh_bcd;
  logic [3:0]  sh_dp;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  bcd_sseg_scan_driver #(
    .DIGITS(D),
    .REFRESH_DIV(R),
    .GUARD(G)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .en(en),
    .bcd(bcd),
    .dp_n(dp_n),
    .an(an),
    .sseg(sseg),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%h req=%h t=%0t", name, got, req, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"}, {4'h0, an}, 8'h0F);
    chk({tag, "_sseg"}, sseg, 8'hFF);
    chk({tag, "_fd"}, {7'h0, frame_done}, 8'h00);
  endtask

  // Compute outputs expected after the coming edge, then advance the model
  task automatic step(input logic en_v, input logic [15:0] b,
                      input logic [3:0] d);
    exp_t x;
    int pos, dig;
    logic [3:0] n;
    logic [6:0] s7;
    en = en_v;
    bcd = b;
    dp_n = d;
    pos = e % R;
    dig = (e / R) % D;
    if (!en_v) begin
      x.an = 4'hF;
      x.sseg = 8'hFF;
      x.fd = 1'b0;
    end else begin
      n = 4'((sh_bcd >> (4 * dig)) & 16'hF);
      s7 = (n <= 4'd9) ? seg_tab[n] : 7'h3F;
`ifdef SSEG_LZ_BLANK_EN
      if (dig > 0 && (sh_bcd >> (4 * dig)) == 16'h0) s7 = 7'h7F;
`endif
      x.sseg = {sh_dp[dig], s7};
      x.an = (pos < G) ? 4'hF : 4'(~(1 << dig));
      x.fd = ((e + 1) % (D * R)) == 0;
      if (x.fd) begin
        sh_bcd = b;
        sh_dp = d;
      end
      e++;
    end
    exp_q.push_back(x);
  endtask

  task automatic cyc(input logic en_v, input logic [15:0] b,
                     input logic [3:0] d);
    step(en_v, b, d);
    @(posedge clk);
    #1;
  endtask

  // Entered and left 1 time unit after a rising edge
  task automatic do_reset();
    exp_t x;
    active = 1'b0;
    exp_q.delete();
    #2 reset_n = 1'b0;
    #1 chk_reset("rst_async");
    repeat (3) begin
      @(negedge clk);
      chk_reset("rst_hold");
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    e = 0;
    sh_bcd = 16'h0;
    sh_dp = 4'hF;
    x.an = 4'hF;
    x.sseg = 8'hFF;
    x.fd = 1'b0;
    exp_q.push_back(x);
    active = 1'b1;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (active) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow got=empty req=entry t=%0t", $time);
        end else begin
          x = exp_q.pop_front();
          chk("an", {4'h0, an}, {4'h0, x.an});
          chk("sseg", sseg, x.sseg);
          chk("frame_done", {7'h0, frame_done}, {7'h0, x.fd});
        end
      end
    end
  end

  function automatic logic [15:0] rnd_bcd();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 4))
      0: return v;
      1: return {4'(v[15:12] % 10), 4'(v[11:8] % 10),
                 4'(v[7:4] % 10), 4'(v[3:0] % 10)};
      2: return v & 16'h00FF;
      3: return v & 16'h000F;
      default: return 16'h0;
    endcase
  endfunction

  task automatic rnd_run(input int n);
    logic [15:0] b;
    logic [3:0] d;
    logic en_v;
    b = rnd_bcd();
    d = 4'($urandom);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) == 0) b = rnd_bcd();
      if ($urandom_range(0, 9) == 0) d = 4'($urandom);
      en_v = ($urandom_range(0, 19) != 0);
      cyc(en_v, b, d);
    end
  endtask

  initial begin : stim
    e = 0;
    sh_bcd = 16'h0;
    sh_dp = 4'hF;
    @(posedge clk);
    #1;
    do_reset();
    repeat (80) cyc(1'b1, 16'h1234, 4'hF);
    repeat (12) cyc(1'b1, 16'h1234, 4'hF);
    repeat (70) cyc(1'b1, 16'h5678, 4'hF);
    repeat (3) cyc(1'b1, 16'h5678, 4'hF);
    repeat (5) cyc(1'b0, 16'h5678, 4'hF);
    repeat (40) cyc(1'b1, 16'h5678, 4'hF);
    repeat (70) cyc(1'b1, 16'h123A, 4'hE);
    repeat (70) cyc(1'b1, 16'h0042, 4'hF);
    repeat (70) cyc(1'b1, 16'h0000, 4'h5);
    rnd_run(1500);
    repeat (5) cyc(1'b1, 16'h9876, 4'hF);
    do_reset();
    rnd_run(800);
    @(negedge clk);
    #1;
    active = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
